imem_load_arbiter: RTL
======================

# imem_load_arbiter

Owns the writable 256×32 instruction memory of the MIPS pipeline and shares its single port between the IF stage and a byte-serial program loader. In normal operation the IF stage reads instructions combinationally at the PC. During a load, the block holds the pipeline, assembles incoming bytes into big-endian words, and writes them sequentially from word 0. It then releases the pipeline for a restart at PC 0.

## Interface
- ADDR_BITS, 8, word-address width; depth = 2^ADDR_BITS = 256 words
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- fetch_addr  in  32  PC from IF; word index = fetch_addr[ADDR_BITS+1:2], low 2 bits and upper bits ignored
- fetch_instr  out  32  instruction at fetch_addr; forced to 0x00000000 (NOP) while cpu_hold=1
- fetch_valid  out  1  1 in RUN, 0 otherwise
- cpu_hold  out  1  stall and PC-reset request to the pipeline
- load_start  in  1  single-cycle request to begin a load, sampled in RUN only
- load_count  in  ADDR_BITS+1  number of words to load, sampled with load_start; legal range 1..256
- load_abort  in  1  aborts an active load
- rx_valid  in  1  loader byte valid
- rx_byte  in  8  loader byte
- rx_ready  out  1  block accepts a byte; 1 only in LOAD
- load_busy  out  1  1 in LOAD and DONE
- load_done  out  1  one-cycle pulse on successful completion
- load_error  out  1  one-cycle pulse on illegal count or abort
- load_ptr  out  ADDR_BITS+1  number of words written in the current or last load

## Operation
- States: RUN (reset state), LOAD, DONE.
- RUN behaviour:
  - cpu_hold=0, fetch_valid=1, rx_ready=0.
  - load_start with load_count in 1..256: go to LOAD and clear word_ptr, byte_cnt, and load_ptr.
  - load_start with load_count=0 or >256: stay in RUN and pulse load_error for one cycle.
- LOAD behaviour:
  - cpu_hold=1, rx_ready=1.
  - Each rx_valid&rx_ready handshake shifts the byte into the assembly register, first byte to bits 31:24 (big-endian), and increments byte_cnt mod 4.
  - On the 4th byte: write {assembled[31:8], rx_byte} to mem[word_ptr] at that edge, then increment word_ptr and load_ptr.
  - Go to DONE when load_ptr reaches load_count.
- DONE: one cycle long. cpu_hold=1, load_done=1, then go to RUN.
- load_abort in LOAD:
  - Go to RUN and pulse load_error.
  - Words already written stay in memory; a partially assembled word is discarded.
  - Abort has priority over a byte handshake in the same cycle (that byte is dropped).
  - load_abort outside LOAD is ignored.
- load_start outside RUN is ignored.
- Memory is initialised to all zeros at time 0. rst_n does not clear memory contents.
- Reset values (asynchronous, immediate on rst_n=0):
  - state=RUN.
  - cpu_hold=0, fetch_valid=1, rx_ready=0, load_busy=0, load_done=0, load_error=0, load_ptr=0.
  - Internal pointers and the assembly register are cleared.
- Reset mid-load: the load is abandoned without a load_error pulse, and completed writes remain. The next load starts at word 0.

## Timing
- Fetch read is combinational, zero cycles from fetch_addr to fetch_instr.
- A memory write occurs on the clock edge that accepts the 4th byte of a word.
- Loader throughput: at most 1 byte per cycle, so a full 256-word image takes 1024 handshake cycles minimum.
- load_start accepted at edge N:
  - LOAD, cpu_hold=1, and rx_ready=1 from cycle N+1.
  - The first byte can be accepted at edge N+1.
- Final word written at edge M: DONE and load_done=1 during cycle M+1, then RUN with cpu_hold=0 from cycle M+2.
- load_error is asserted during the cycle after the offending edge.
- rx_ready, cpu_hold, fetch_valid, and load_busy are decoded directly from the state register, with no dependency on rx_valid.

## Test plan
- Reset, then fetch_addr=0x8: fetch_instr=0x00000000, fetch_valid=1, cpu_hold=0, all pulses 0.
- load_count=2, back-to-back bytes 20 08 00 05 8C 09 00 04:
  - mem[0]=0x20080005 and mem[1]=0x8C090004.
  - load_done high exactly one cycle after the 8th-byte edge; cpu_hold high from load_start+1 through DONE.
  - Then fetch_addr=0x4 returns 0x8C090004, and fetch_addr=0x404 wraps to the same word.
- Same two-word load with 1–3 idle cycles between rx_valid pulses: identical memory contents, load_ptr=2, and no byte is accepted while rx_ready=0.
- load_count=0, and separately load_count=257: one-cycle load_error pulse, state stays RUN, cpu_hold never rises, memory unchanged.
- load_count=4, 5 bytes accepted, then load_abort in the same cycle as a 6th byte:
  - mem[0] written, mem[1] unchanged, load_error pulse, return to RUN, load_ptr=1.
  - A following 1-word load overwrites mem[0].
- rst_n low after 6 bytes of a 2-word load:
  - All outputs return to reset values asynchronously, and mem[0] is retained.
  - The next load of 1 word writes mem[0] again, with load_done one cycle after its 4th byte.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Holds the writable instruction memory of the MIPS pipeline. The memory has
//   one port, shared by two users:
//   - the IF stage, which reads it combinationally, and
//   - a byte-serial program loader.
//   During a load the pipeline is held. Incoming bytes are packed big-endian
//   into words and written from word 0 upward. When the load ends, the
//   pipeline is released so that it restarts at PC 0.
//
// Ports
//   clk, rst_n      clock, async active-low reset (memory contents survive reset)
//   fetch_addr      PC from IF; word index taken from [ADDR_BITS+1:2]
//   fetch_instr     instruction at fetch_addr; NOP (0) while cpu_hold
//   fetch_valid     high in RUN
//   cpu_hold        stall / PC-reset request, high in LOAD and DONE
//   load_start      request a load; load_count words (legal 1..DEPTH)
//   load_abort      abandon an active load
//   rx_valid/rx_byte/rx_ready  loader byte handshake, ready only in LOAD
//   load_busy       high in LOAD and DONE
//   load_done       one-cycle pulse after the final word is written
//   load_error      one-cycle pulse after an illegal count or an abort
//   load_ptr        words written by the current or last load
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | pipeline owns the memory, fetches are valid
// LOAD  | pipeline held, bytes assembled and written sequentially
// DONE  | single cycle, load_done pulse, pipeline still held

module imem_load_arbiter #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          fetch_addr,
  output logic [31:0]          fetch_instr,
  output logic                 fetch_valid,
  output logic                 cpu_hold,
  input  logic                 load_start,
  input  logic [ADDR_BITS:0]   load_count,
  input  logic                 load_abort,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 rx_ready,
  output logic                 load_busy,
  output logic                 load_done,
  output logic                 load_error,
  output logic [ADDR_BITS:0]   load_ptr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Zero image at time 0; rst_n deliberately leaves the contents alone.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  logic [ADDR_BITS-1:0] word_ptr;
  logic [1:0]           byte_cnt;
  logic [23:0]          asm_q;       // first three bytes of the word in flight
  logic [CW-1:0]        load_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 err_q;

  logic count_legal;
  logic accept;
  logic word_wr;
  logic start_ok;
  logic err_set;
  logic [31:0] fetch_word;

  assign count_legal = (load_count != '0) && (load_count <= CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cpu_hold    = 1'b0;
    fetch_valid = 1'b0;
    rx_ready    = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    accept      = 1'b0;
    word_wr     = 1'b0;
    start_ok    = 1'b0;
    err_set     = 1'b0;
    case (state)
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (load_start) begin
          if (count_legal) begin
            start_ok = 1'b1;
            state_nx = ST_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        cpu_hold  = 1'b1;
        rx_ready  = 1'b1;
        load_busy = 1'b1;
        // Abort wins over a byte offered in the same cycle; that byte is dropped.
        if (load_abort) begin
          err_set  = 1'b1;
          state_nx = ST_RUN;
        end else if (rx_valid) begin
          accept = 1'b1;
          if (byte_cnt == 2'd3) begin
            word_wr = 1'b1;
            if (load_ptr_q + CW'(1) == count_q) state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        cpu_hold  = 1'b1;
        load_busy = 1'b1;
        load_done = 1'b1;
        state_nx  = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ptr   <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      load_ptr_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_set;
      if (start_ok) begin
        word_ptr   <= '0;
        byte_cnt   <= '0;
        asm_q      <= '0;
        load_ptr_q <= '0;
        count_q    <= load_count;
      end else if (accept) begin
        asm_q    <= {asm_q[15:0], rx_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (word_wr) begin
          word_ptr   <= word_ptr + 1'b1;
          load_ptr_q <= load_ptr_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_wr) mem[word_ptr] <= {asm_q, rx_byte};
  end

  assign fetch_word  = mem[fetch_addr[ADDR_BITS+1:2]];
  assign fetch_instr = cpu_hold ? 32'h0 : fetch_word;
  assign load_error  = err_q;
  assign load_ptr    = load_ptr_q;

  // Byte-offset and out-of-range PC bits play no part in the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_addr[31:ADDR_BITS+2], fetch_addr[1:0]};

endmodule
